// File: rtl/trail_board.sv
// ============================================================================
//  trail_board : light-cycle playfield occupancy store with clear sweep
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module trail_board #(
    parameter int X_LO = 11,
    parameter int X_HI = 148,
    parameter int Y_LO = 18,
    parameter int Y_HI = 107
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear_req,
    output logic       busy,
    output logic       clear_done,
    input  logic       mark_req,
    input  logic [7:0] mark_x,
    input  logic [6:0] mark_y,
    input  logic       query_req,
    input  logic [7:0] query_x,
    input  logic [6:0] query_y,
    output logic       query_valid,
    output logic       query_hit,
    output logic       clr_plot,
    output logic [7:0] clr_x,
    output logic [6:0] clr_y
);

    localparam int W     = X_HI - X_LO + 1;
    localparam int H     = Y_HI - Y_LO + 1;
    localparam int DEPTH = W * H;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cx;
    logic [6:0]  r_cy;
    logic        r_qvalid;
    logic        r_qoor;
    logic        r_ram_q;

    logic        mem [0:DEPTH-1];

    logic        w_accept;
    logic        w_we;
    logic        w_wdata;
    logic [13:0] w_waddr;
    logic [13:0] w_raddr;

    function automatic logic in_field(input logic [7:0] x, input logic [6:0] y);
        return (x >= 8'(X_LO)) && (x <= 8'(X_HI)) && (y >= 7'(Y_LO)) && (y <= 7'(Y_HI));
    endfunction

    // Subtractions are 8-bit; the result is a 14-bit row-major cell index.
    function automatic logic [13:0] cell_idx(input logic [7:0] x, input logic [6:0] y);
        logic [7:0] dx;
        logic [7:0] dy;
        dx = x - 8'(X_LO);
        dy = {1'b0, y} - 8'(Y_LO);
        return 14'(dy) * 14'(W) + 14'(dx);
    endfunction

    assign w_accept = (r_state == S_IDLE) && !busy && !clear_req;

    always_comb begin
        w_we    = 1'b0;
        w_wdata = 1'b0;
        w_waddr = cell_idx(r_cx, r_cy);
        if (r_state == S_CLEAR) begin
            w_we = 1'b1;
        end else if (w_accept && mark_req && in_field(mark_x, mark_y)) begin
            w_we    = 1'b1;
            w_wdata = 1'b1;
            w_waddr = cell_idx(mark_x, mark_y);
        end
    end

    assign w_raddr = in_field(query_x, query_y) ? cell_idx(query_x, query_y) : 14'd0;

    // Plain RAM: the read samples the old contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
        r_ram_q <= mem[w_raddr];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_CLEAR;
            r_cx       <= 8'(X_LO);
            r_cy       <= 7'(Y_LO);
            busy       <= 1'b1;
            clear_done <= 1'b0;
            r_qvalid   <= 1'b0;
            r_qoor     <= 1'b0;
            clr_plot   <= 1'b0;
            clr_x      <= 8'd0;
            clr_y      <= 7'd0;
        end else begin
            clear_done <= 1'b0;
            clr_plot   <= 1'b0;
            r_qvalid   <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    clr_plot <= 1'b1;
                    clr_x    <= r_cx;
                    clr_y    <= r_cy;
                    if (r_cx == 8'(X_HI)) begin
                        r_cx <= 8'(X_LO);
                        if (r_cy == 7'(Y_HI)) begin
                            r_cy       <= 7'(Y_LO);
                            r_state    <= S_IDLE;
                            clear_done <= 1'b1;
                        end else begin
                            r_cy <= r_cy + 7'd1;
                        end
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                end
                S_IDLE: begin
                    // busy is still high for one idle cycle after the last plot
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (clear_req) begin
                        r_state <= S_CLEAR;
                        r_cx    <= 8'(X_LO);
                        r_cy    <= 7'(Y_LO);
                        busy    <= 1'b1;
                    end else begin
                        r_qvalid <= query_req;
                        r_qoor   <= !in_field(query_x, query_y);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign query_valid = r_qvalid;
    assign query_hit   = r_qvalid & (r_qoor | r_ram_q);

endmodule

`default_nettype wire
